// File: rtl/count_chk_pkg.sv
// count_chk_pkg: shared state encoding, count limits and vector types for the step checker
package count_chk_pkg;
    localparam int WIDTH_DEF = 4;
    localparam int LAP_W_DEF = 8;
    localparam int ERR_W_DEF = 4;
    localparam int CNT_MAX = 2**WIDTH_DEF - 1;
    typedef enum logic [1:0] {INIT, TRACK, FAULT} state_t;
    typedef logic [WIDTH_DEF-1:0] cnt_t;
    typedef logic signed [LAP_W_DEF-1:0] lap_t;
    typedef logic [ERR_W_DEF-1:0] err_t;
endpackage

// File: rtl/count_step_checker_step_predict.sv
// step_predict: legal next value of the counter and wrap classification of the current step
module step_predict #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] prev_count,
    input  logic             prev_ud,
    input  logic [WIDTH-1:0] Count,
    output logic [WIDTH-1:0] expected,
    output logic             match,
    output logic             is_wrap_up,
    output logic             is_wrap_dn
);
    always_comb begin
        expected   = prev_ud ? prev_count + 1'b1 : prev_count - 1'b1;
        match      = Count == expected;
        is_wrap_up = prev_ud && prev_count == {WIDTH{1'b1}};
        is_wrap_dn = !prev_ud && prev_count == '0;
    end
endmodule

// File: rtl/count_step_checker.sv
// count_step_checker: checks every counter transition for a legal +/-1 step, tallies laps and errors
module count_step_checker
    import count_chk_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int LAP_W   = 8,
    parameter int ERR_W   = 4,
    parameter int MAX_ERR = 3
) (
    input  logic             CLK,
    input  logic             Clear,
    input  logic             UD,
    input  logic [WIDTH-1:0] Count,
    output logic [WIDTH-1:0] exp_count,
    output logic             wrap_up,
    output logic             wrap_dn,
    output logic             step_err,
    output logic [ERR_W-1:0] err_count,
    output logic [LAP_W-1:0] lap_count,
    output logic             fault,
    output logic             tracking
);
    state_t state, state_nxt;
    logic [WIDTH-1:0] prev_count, nxt_exp, unused_expected;
    logic prev_ud, match, is_wrap_up, is_wrap_dn, chk, bad;
    logic [ERR_W-1:0] err_inc;

    step_predict #(.WIDTH(WIDTH)) u_pred (
        .prev_count(prev_count),
        .prev_ud(prev_ud),
        .Count(Count),
        .expected(unused_expected),
        .match(match),
        .is_wrap_up(is_wrap_up),
        .is_wrap_dn(is_wrap_dn)
    );

    assign chk     = state == TRACK;
    assign bad     = chk && !match;
    assign nxt_exp = UD ? Count + 1'b1 : Count - 1'b1;
    assign err_inc = &err_count ? err_count : err_count + 1'b1;

    always_ff @(posedge CLK)
        state <= !Clear ? INIT : state_nxt;

    always_comb
        state_nxt = state == INIT ? TRACK :
                    (bad && err_inc == ERR_W'(MAX_ERR)) ? FAULT : state;

    always_comb begin
        fault    = state == FAULT;
        tracking = state == TRACK;
    end

    // FAULT freezes the prediction and both tallies until the next Clear
    always_ff @(posedge CLK) begin
        if (!Clear) begin
            prev_count <= '0;
            prev_ud    <= 1'b0;
            exp_count  <= '0;
            wrap_up    <= 1'b0;
            wrap_dn    <= 1'b0;
            step_err   <= 1'b0;
            err_count  <= '0;
            lap_count  <= '0;
        end else begin
            wrap_up  <= chk && match && is_wrap_up;
            wrap_dn  <= chk && match && is_wrap_dn;
            step_err <= bad;
            if (state != FAULT) begin
                prev_count <= Count;
                prev_ud    <= UD;
                exp_count  <= nxt_exp;
            end
            if (bad)
                err_count <= err_inc;
            if (chk && match && is_wrap_up)
                lap_count <= lap_count + 1'b1;
            else if (chk && match && is_wrap_dn)
                lap_count <= lap_count - 1'b1;
        end
    end
endmodule

// File: tb/tb_count_step_checker.sv
// tb_count_step_checker: queue scoreboard against a reference model plus hand-derived spot values
module tb_count_step_checker;
    import count_chk_pkg::*;

    typedef struct packed {
        cnt_t       exp_count;
        logic       wu, wd, se;
        err_t       err;
        logic [7:0] lap;
        logic       fault, trk;
    } exp_t;

    logic CLK, Clear, UD;
    cnt_t Count, exp_count;
    logic wrap_up, wrap_dn, step_err, fault, tracking;
    err_t err_count;
    logic [7:0] lap_count;

    count_step_checker dut (
        .CLK(CLK), .Clear(Clear), .UD(UD), .Count(Count),
        .exp_count(exp_count), .wrap_up(wrap_up), .wrap_dn(wrap_dn),
        .step_err(step_err), .err_count(err_count), .lap_count(lap_count),
        .fault(fault), .tracking(tracking)
    );

    exp_t sb[$];
    int checks = 0, errors = 0, cyc = 0;
    int wu_seen = 0, wd_seen = 0, se_seen = 0;
    int ms = 0, mp = 0, mu = 0, merr = 0, mlap = 0;
    cnt_t me = '0;
    cnt_t ctr;
    int wu0, se0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    function automatic exp_t model(input logic clr, input logic ud, input cnt_t c);
        exp_t r;
        int want;
        r = '0;
        if (!clr) begin
            ms = 0; mp = 0; mu = 0; me = '0; merr = 0; mlap = 0;
        end else if (ms != 2) begin
            if (ms == 1) begin
                want = (mp + (mu != 0 ? 1 : CNT_MAX)) % (CNT_MAX + 1);
                if (int'(c) == want) begin
                    r.wu = mu != 0 && mp == CNT_MAX;
                    r.wd = mu == 0 && mp == 0;
                    mlap = mlap + (r.wu ? 1 : 0) - (r.wd ? 1 : 0);
                end else begin
                    r.se = 1'b1;
                    if (merr < 15) merr++;
                    if (merr == 3) ms = 2;
                end
            end else ms = 1;
            mp = int'(c);
            mu = int'(ud);
            me = cnt_t'((int'(c) + (ud ? 1 : CNT_MAX)) % (CNT_MAX + 1));
        end
        r.exp_count = me;
        r.err = err_t'(merr);
        r.lap = 8'(mlap);
        r.fault = ms == 2;
        r.trk = ms == 1;
        return r;
    endfunction

    task automatic tick(input logic clr, input logic ud, input cnt_t c);
        @(negedge CLK);
        Clear = clr;
        UD = ud;
        Count = c;
        sb.push_back(model(clr, ud, c));
        @(posedge CLK);
        #2;
    endtask

    task automatic hc(input string n, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", n, act, want);
        end
    endtask

    initial begin
        exp_t e, a;
        forever begin
            @(posedge CLK);
            #1;
            cyc++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                a = '{exp_count, wrap_up, wrap_dn, step_err, err_count, lap_count, fault, tracking};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL scoreboard cyc %0d got exp=%0d wu=%b wd=%b se=%b err=%0d lap=%0d flt=%b trk=%b want exp=%0d wu=%b wd=%b se=%b err=%0d lap=%0d flt=%b trk=%b",
                             cyc, a.exp_count, a.wu, a.wd, a.se, a.err, a.lap, a.fault, a.trk,
                             e.exp_count, e.wu, e.wd, e.se, e.err, e.lap, e.fault, e.trk);
                end
                wu_seen += int'(wrap_up);
                wd_seen += int'(wrap_dn);
                se_seen += int'(step_err);
            end
        end
    end

    initial begin
        Clear = 1'b0; UD = 1'b0; Count = '0;
        tick(0, 1, 0);
        hc("reset_exp", int'(exp_count), 0);
        hc("reset_trk", int'(tracking), 0);
        hc("reset_err", int'(err_count), 0);
        // real counter counting up from reset: 0..15,0..3
        ctr = '0;
        for (int i = 0; i < 20; i++) begin
            tick(1, 1, ctr);
            ctr = ctr + 1'b1;
        end
        hc("up_wraps", wu_seen, 1);
        hc("up_lap", int'($signed(lap_count)), 1);
        hc("up_trk", int'(tracking), 1);
        hc("up_err", int'(err_count), 0);
        hc("up_exp", int'(exp_count), 4);
        // from 3: six more up, then down through the 0->15 wrap
        for (int i = 0; i < 18; i++) begin
            tick(1, i < 6, ctr);
            ctr = (i < 6) ? ctr + 1'b1 : ctr - 1'b1;
        end
        hc("dn_wraps", wd_seen, 1);
        hc("dn_lap", int'($signed(lap_count)), 0);
        hc("dn_err", int'(err_count), 0);
        hc("dn_exp", int'(exp_count), 14);
        // directed 4,5,7,8
        tick(0, 1, 0);
        tick(1, 1, 4);
        tick(1, 1, 5);
        tick(1, 1, 7);
        hc("skip_se", int'(step_err), 1);
        hc("skip_err", int'(err_count), 1);
        tick(1, 1, 8);
        hc("resync_se", int'(step_err), 0);
        hc("resync_exp", int'(exp_count), 9);
        // two more illegal steps reach MAX_ERR
        tick(1, 1, 3);
        hc("err2", int'(err_count), 2);
        tick(1, 1, 10);
        hc("fault_se", int'(step_err), 1);
        hc("fault_set", int'(fault), 1);
        hc("fault_err", int'(err_count), 3);
        hc("fault_trk", int'(tracking), 0);
        se0 = se_seen;
        tick(1, 1, 15);
        tick(1, 1, 0);
        tick(1, 0, 7);
        hc("frozen_pulses", se_seen - se0, 0);
        hc("frozen_err", int'(err_count), 3);
        hc("frozen_exp", int'(exp_count), 11);
        // clear out of FAULT, then a legal wrapping run
        tick(0, 1, 5);
        hc("clr_fault", int'(fault), 0);
        hc("clr_err", int'(err_count), 0);
        hc("clr_exp", int'(exp_count), 0);
        wu0 = wu_seen;
        tick(1, 1, 14);
        tick(1, 1, 15);
        tick(1, 1, 0);
        tick(1, 1, 1);
        hc("rerun_wrap", wu_seen - wu0, 1);
        hc("rerun_lap", int'($signed(lap_count)), 1);
        hc("rerun_err", int'(err_count), 0);
        // held value is illegal
        tick(0, 1, 0);
        tick(1, 1, 9);
        tick(1, 1, 9);
        hc("hold_se", int'(step_err), 1);
        hc("hold_err", int'(err_count), 1);
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge CLK);
        #3;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
